// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: ALU control encodings,
// FSM state type and a small one-hot helper.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: a lone requester wins; under contention the priority
// pointer picks the winner and then flips to the loser.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_any = en & (|req);
    gnt_idx = (req == 2'b11) ? ptr_q : req[1];
    gnt     = gnt_any ? onehot2(gnt_idx) : 2'b00;
    ptr_d   = gnt_any ? ~gnt_idx : ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant in IDLE, one cycle
// of execution, then hold the result until the owner accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*4-1:0]      req_ctl,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_zero,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [3:0]             alu_ctl,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_zero,
  output logic                   busy
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        ctl_q, ctl_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       gnt_any;

  // Arbitration is suppressed during reset so req_ready stays low.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      ((state_q == ST_IDLE) && !reset),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d = gnt_idx;
          a_d     = gnt_idx ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
          b_d     = gnt_idx ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
          ctl_d   = gnt_idx ? req_ctl[4 +: 4] : req_ctl[0 +: 4];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == ST_RESP) ? onehot2(owner_q) : 2'b00;
  assign rsp_data  = res_q;
  assign rsp_zero  = zero_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctl   = ctl_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the
// external ALU; vector table plus contention, backpressure and reset sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [7:0]    req_ctl;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_ctl;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .NREQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctl   (req_ctl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctl   (alu_ctl),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .busy      (busy)
  );

  // External ALU model
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SLL: alu_out = alu_a << alu_b[5:0];
      ALU_SLT: alu_out = {63'd0, ($signed(alu_a) < $signed(alu_b))};
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_SRL: alu_out = alu_a >> alu_b[5:0];
      ALU_SRA: alu_out = $signed(alu_a) >>> alu_b[5:0];
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct {
    string       name;
    logic        idx;
    logic [3:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic idx, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] ctl);
    if (idx) begin
      req_a[DW +: DW] = a;
      req_b[DW +: DW] = b;
      req_ctl[7:4]    = ctl;
    end else begin
      req_a[0 +: DW]  = a;
      req_b[0 +: DW]  = b;
      req_ctl[3:0]    = ctl;
    end
    req_valid[idx] = 1'b1;
  endtask

  // Starts in an IDLE cycle with requests already driven; ends #1 after the
  // negedge of the cycle following acceptance of the response.
  task automatic run_txn(input string name, input logic owner, input logic [3:0] exp_ctl,
                         input logic [63:0] exp_data, input logic exp_zero,
                         input bit clear_req);
    #1;
    chk({name, " req_ready@N"}, 64'(req_ready), 64'(onehot2(owner)));
    chk({name, " busy@N"}, 64'(busy), 64'd0);
    @(negedge clk);
    if (clear_req) req_valid = 2'b00;
    #1;
    chk({name, " busy@N+1"}, 64'(busy), 64'd1);
    chk({name, " req_ready@N+1"}, 64'(req_ready), 64'd0);
    chk({name, " rsp_valid@N+1"}, 64'(rsp_valid), 64'd0);
    chk({name, " alu_ctl"}, 64'(alu_ctl), 64'(exp_ctl));
    @(negedge clk);
    #1;
    chk({name, " rsp_valid@N+2"}, 64'(rsp_valid), 64'(onehot2(owner)));
    chk({name, " rsp_data"}, rsp_data, exp_data);
    chk({name, " rsp_zero"}, 64'(rsp_zero), 64'(exp_zero));
    rsp_ready = onehot2(owner);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk({name, " rsp_valid after accept"}, 64'(rsp_valid), 64'd0);
    chk({name, " busy after accept"}, 64'(busy), 64'd0);
    $display("[TB] txn %s owner=%0d data=0x%0h zero=%0d", name, owner, rsp_data, rsp_zero);
  endtask

  initial begin
    vecs[0] = '{"add",   1'b0, ALU_ADD, 64'd5, 64'd7, 64'd12, 1'b0};
    vecs[1] = '{"and",   1'b1, ALU_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0};
    vecs[2] = '{"or",    1'b0, ALU_OR,  64'hF000, 64'h000F, 64'hF00F, 1'b0};
    vecs[3] = '{"sub",   1'b1, ALU_SUB, 64'd9, 64'd9, 64'd0, 1'b1};
    vecs[4] = '{"sll",   1'b0, ALU_SLL, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0};
    vecs[5] = '{"slt",   1'b1, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0};
    vecs[6] = '{"xor",   1'b0, ALU_XOR, 64'hFF, 64'h0F, 64'hF0, 1'b0};
    vecs[7] = '{"srl",   1'b1, ALU_SRL, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0};
    vecs[8] = '{"undef", 1'b1, 4'b1111, 64'd123, 64'd456, 64'd0, 1'b1};
    vecs[9] = '{"sra",   1'b0, ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0};

    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = '1;
    req_b     = '1;
    req_ctl   = '1;
    rsp_ready = 2'b11;

    // Outputs under reset, with every input pushing the other way
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset alu_a", alu_a, 64'd0);
    chk("reset alu_b", alu_b, 64'd0);
    chk("reset alu_ctl", 64'(alu_ctl), 64'd0);
    chk("reset rsp_data", rsp_data, 64'd0);
    chk("reset rsp_zero", 64'(rsp_zero), 64'd0);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single-requester vectors; the idle requester carries decoy operands
    for (int i = 0; i < 10; i++) begin
      set_req(~vecs[i].idx, ~vecs[i].a, ~vecs[i].b, ALU_OR);
      req_valid = 2'b00;
      set_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].ctl);
      run_txn(vecs[i].name, vecs[i].idx, vecs[i].ctl, vecs[i].exp_data, vecs[i].exp_zero, 1'b1);
    end

    // Contention after reset: the pointer must restart at requester 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b00;
    set_req(1'b0, 64'd1, 64'd2, ALU_ADD);
    set_req(1'b1, 64'd9, 64'd9, ALU_SUB);
    run_txn("cont0", 1'b0, ALU_ADD, 64'd3, 1'b0, 1'b0);
    run_txn("cont1", 1'b1, ALU_SUB, 64'd0, 1'b1, 1'b0);
    run_txn("cont2", 1'b0, ALU_ADD, 64'd3, 1'b0, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);

    // Backpressure: owner withholds rsp_ready, the other bit and requester push
    set_req(1'b0, 64'd20, 64'd22, ALU_ADD);
    #1;
    chk("bp req_ready@N", 64'(req_ready), 64'd1);
    @(negedge clk);
    set_req(1'b1, 64'd100, 64'd1, ALU_SUB);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b10;
      #1;
      chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp rsp_data", rsp_data, 64'd42);
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    req_valid = 2'b00;
    #1;
    chk("bp rsp_valid before accept", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("bp rsp_valid after accept", 64'(rsp_valid), 64'd0);
    chk("bp busy after accept", 64'(busy), 64'd0);
    $display("[TB] txn backpressure data=0x%0h", rsp_data);

    // Reset while the transaction is in EXEC
    set_req(1'b1, 64'd3, 64'd4, ALU_ADD);
    #1;
    chk("rst req_ready@N", 64'(req_ready), 64'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rst busy in EXEC", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst alu_a", alu_a, 64'd0);
    chk("rst rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst no rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst stays idle", 64'(busy), 64'd0);
    end
    $display("[TB] txn reset-mid-op discarded");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
